// File: rtl/window_addr_gen.sv
// Sliding-window read-address generator: sweeps a KxK window with stride over NUM_CH
// row-major images stored back-to-back, emitting one tap address per enabled RUN cycle.
module window_addr_gen #(
    parameter int IMG_W       = 12,
    parameter int IMG_H       = 12,
    parameter int K           = 5,
    parameter int STRIDE      = 1,
    parameter int NUM_CH      = 2,
    parameter int START_DELAY = 0,
    parameter int ADDR_W      = 9,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              start,
    output logic [ADDR_W-1:0] addr,
    output logic              addr_valid,
    output logic              win_first,
    output logic              win_last,
    output logic [CH_W-1:0]   chan,
    output logic              done
);

    localparam int OUT_W = (IMG_W - K) / STRIDE + 1;
    localparam int OUT_H = (IMG_H - K) / STRIDE + 1;
    localparam int KW    = (K > 1) ? $clog2(K) : 1;
    localparam int OWW   = (OUT_W > 1) ? $clog2(OUT_W) : 1;
    localparam int OHW   = (OUT_H > 1) ? $clog2(OUT_H) : 1;
    localparam int DW    = (START_DELAY > 0) ? $clog2(START_DELAY + 1) : 1;

    localparam logic [KW-1:0]     K_LAST    = KW'(K - 1);
    localparam logic [OWW-1:0]    OCOL_LAST = OWW'(OUT_W - 1);
    localparam logic [OHW-1:0]    OROW_LAST = OHW'(OUT_H - 1);
    localparam logic [CH_W-1:0]   C_LAST    = CH_W'(NUM_CH - 1);
    localparam logic [DW-1:0]     D_LAST    = DW'(START_DELAY);
    localparam logic [ADDR_W-1:0] LINE      = ADDR_W'(IMG_W);
    localparam logic [ADDR_W-1:0] COL_STEP  = ADDR_W'(STRIDE);
    localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(STRIDE * IMG_W);
    localparam logic [ADDR_W-1:0] CH_STEP   = ADDR_W'(IMG_W * IMG_H);

    if (K > IMG_W || K > IMG_H) begin : g_err_k
        $error("window_addr_gen: K larger than image");
    end else if ((IMG_W - K) % STRIDE != 0 || (IMG_H - K) % STRIDE != 0) begin : g_err_stride
        $error("window_addr_gen: stride does not tile the image");
    end
    if ((2 ** ADDR_W) < NUM_CH * IMG_W * IMG_H) begin : g_err_addr
        $error("window_addr_gen: ADDR_W too small");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_DELAY,
        S_RUN,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [DW-1:0]     dly_q, dly_d;
    logic [CH_W-1:0]   c_q, c_d;
    logic [OHW-1:0]    orow_q, orow_d;
    logic [OWW-1:0]    ocol_q, ocol_d;
    logic [KW-1:0]     kr_q, kr_d;
    logic [KW-1:0]     kc_q, kc_d;
    logic [ADDR_W-1:0] chan_base_q, chan_base_d;
    logic [ADDR_W-1:0] row_base_q, row_base_d;
    logic [ADDR_W-1:0] win_base_q, win_base_d;
    logic [ADDR_W-1:0] tap_row_q, tap_row_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              valid_q, valid_d;
    logic              first_q, first_d;
    logic              last_q, last_d;
    logic              done_q, done_d;

    logic kc_wrap, kr_wrap, ocol_wrap, orow_wrap, c_last, final_tap;

    assign kc_wrap   = (kc_q == K_LAST);
    assign kr_wrap   = (kr_q == K_LAST);
    assign ocol_wrap = (ocol_q == OCOL_LAST);
    assign orow_wrap = (orow_q == OROW_LAST);
    assign c_last    = (c_q == C_LAST);
    assign final_tap = kc_wrap && kr_wrap && ocol_wrap && orow_wrap && c_last;

    always_comb begin
        state_d     = state_q;
        dly_d       = dly_q;
        c_d         = c_q;
        orow_d      = orow_q;
        ocol_d      = ocol_q;
        kr_d        = kr_q;
        kc_d        = kc_q;
        chan_base_d = chan_base_q;
        row_base_d  = row_base_q;
        win_base_d  = win_base_q;
        tap_row_d   = tap_row_q;
        addr_d      = addr_q;
        valid_d     = valid_q;
        first_d     = first_q;
        last_d      = last_q;
        done_d      = done_q;

        if (enable) begin
            unique case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_d     = S_DELAY;
                        dly_d       = '0;
                        c_d         = '0;
                        orow_d      = '0;
                        ocol_d      = '0;
                        kr_d        = '0;
                        kc_d        = '0;
                        chan_base_d = '0;
                        row_base_d  = '0;
                        win_base_d  = '0;
                        tap_row_d   = '0;
                        addr_d      = '0;
                        first_d     = 1'b0;
                        last_d      = 1'b0;
                        done_d      = 1'b0;
                    end
                end
                S_DELAY: begin
                    if (dly_q == D_LAST) begin
                        state_d = S_RUN;
                        valid_d = 1'b1;
                        first_d = 1'b1;
                        last_d  = (K == 1);
                    end else begin
                        dly_d = dly_q + 1'b1;
                    end
                end
                S_RUN: begin
                    if (final_tap) begin
                        state_d = S_DONE;
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        // Each wrap level reloads the bases below it from its own running base,
                        // so the address is built from adds only.
                        if (!kc_wrap) begin
                            kc_d   = kc_q + 1'b1;
                            addr_d = addr_q + 1'b1;
                        end else begin
                            kc_d = '0;
                            if (!kr_wrap) begin
                                kr_d      = kr_q + 1'b1;
                                tap_row_d = tap_row_q + LINE;
                            end else begin
                                kr_d = '0;
                                if (!ocol_wrap) begin
                                    ocol_d     = ocol_q + 1'b1;
                                    win_base_d = win_base_q + COL_STEP;
                                end else begin
                                    ocol_d = '0;
                                    if (!orow_wrap) begin
                                        orow_d     = orow_q + 1'b1;
                                        row_base_d = row_base_q + ROW_STEP;
                                    end else begin
                                        orow_d      = '0;
                                        c_d         = c_q + 1'b1;
                                        chan_base_d = chan_base_q + CH_STEP;
                                        row_base_d  = chan_base_d;
                                    end
                                    win_base_d = row_base_d;
                                end
                                tap_row_d = win_base_d;
                            end
                            addr_d = tap_row_d;
                        end
                        first_d = (kc_d == '0) && (kr_d == '0);
                        last_d  = (kc_d == K_LAST) && (kr_d == K_LAST);
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            dly_q       <= '0;
            c_q         <= '0;
            orow_q      <= '0;
            ocol_q      <= '0;
            kr_q        <= '0;
            kc_q        <= '0;
            chan_base_q <= '0;
            row_base_q  <= '0;
            win_base_q  <= '0;
            tap_row_q   <= '0;
            addr_q      <= '0;
            valid_q     <= 1'b0;
            first_q     <= 1'b0;
            last_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            dly_q       <= dly_d;
            c_q         <= c_d;
            orow_q      <= orow_d;
            ocol_q      <= ocol_d;
            kr_q        <= kr_d;
            kc_q        <= kc_d;
            chan_base_q <= chan_base_d;
            row_base_q  <= row_base_d;
            win_base_q  <= win_base_d;
            tap_row_q   <= tap_row_d;
            addr_q      <= addr_d;
            valid_q     <= valid_d;
            first_q     <= first_d;
            last_q      <= last_d;
            done_q      <= done_d;
        end
    end

    // A held tap is only consumed on a cycle where enable lets the generator advance.
    assign addr_valid = valid_q && enable;
    assign addr       = addr_q;
    assign win_first  = first_q;
    assign win_last   = last_q;
    assign chan       = c_q;
    assign done       = done_q;

endmodule

// File: tb/tb_window_addr_gen.sv
// Scoreboard bench for window_addr_gen: default geometry, a strided 6x6 image, and a
// delayed-start instance driven with random enable stalls.
module tb_window_addr_gen;

    typedef struct packed {
        logic [8:0] addr;
        logic       chan;
        logic       first;
        logic       last;
    } beat_t;

    logic clk, rst, start, enable;
    int   sel;
    int   checks, errors;
    beat_t exp_q[$];

    logic [8:0] addr_a, addr_b, addr_c;
    logic       valid_a, valid_b, valid_c;
    logic       first_a, first_b, first_c;
    logic       last_a, last_b, last_c;
    logic       chan_a, chan_b, chan_c;
    logic       done_a, done_b, done_c;
    logic       start_a, start_b, start_c;

    logic [8:0] obs_addr;
    logic       obs_valid, obs_first, obs_last, obs_chan, obs_done;

    assign start_a = start && (sel == 0);
    assign start_b = start && (sel == 1);
    assign start_c = start && (sel == 2);

    window_addr_gen u_a (
        .clk(clk), .reset(rst), .enable(enable), .start(start_a),
        .addr(addr_a), .addr_valid(valid_a), .win_first(first_a), .win_last(last_a),
        .chan(chan_a), .done(done_a)
    );

    window_addr_gen #(.IMG_W(6), .IMG_H(6), .K(2), .STRIDE(2), .NUM_CH(1)) u_b (
        .clk(clk), .reset(rst), .enable(enable), .start(start_b),
        .addr(addr_b), .addr_valid(valid_b), .win_first(first_b), .win_last(last_b),
        .chan(chan_b), .done(done_b)
    );

    window_addr_gen #(.START_DELAY(3)) u_c (
        .clk(clk), .reset(rst), .enable(enable), .start(start_c),
        .addr(addr_c), .addr_valid(valid_c), .win_first(first_c), .win_last(last_c),
        .chan(chan_c), .done(done_c)
    );

    always_comb begin
        obs_addr = addr_a; obs_valid = valid_a; obs_first = first_a;
        obs_last = last_a; obs_chan = chan_a;   obs_done = done_a;
        if (sel == 1) begin
            obs_addr = addr_b; obs_valid = valid_b; obs_first = first_b;
            obs_last = last_b; obs_chan = chan_b;   obs_done = done_b;
        end else if (sel == 2) begin
            obs_addr = addr_c; obs_valid = valid_c; obs_first = first_c;
            obs_last = last_c; obs_chan = chan_c;   obs_done = done_c;
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push_expected(input int w, input int h, input int k, input int s, input int nch);
        int ow, oh;
        beat_t e;
        ow = (w - k) / s + 1;
        oh = (h - k) / s + 1;
        exp_q.delete();
        for (int c = 0; c < nch; c++)
            for (int orow = 0; orow < oh; orow++)
                for (int ocol = 0; ocol < ow; ocol++)
                    for (int kr = 0; kr < k; kr++)
                        for (int kc = 0; kc < k; kc++) begin
                            e.addr  = 9'(c * w * h + (orow * s + kr) * w + ocol * s + kc);
                            e.chan  = (c != 0);
                            e.first = (kr == 0) && (kc == 0);
                            e.last  = (kr == k - 1) && (kc == k - 1);
                            exp_q.push_back(e);
                        end
    endtask

    // Drives one run on DUT `which` and checks every produced beat against the scoreboard.
    task automatic run_scenario(input int which, input int stall_pct, input int pulse_at,
                                input int reset_at, input int exp_lat, input int total);
        int    beats, m, spot;
        bit    finished, pulsed;
        beat_t e, got;
        if (which == 1) push_expected(6, 6, 2, 2, 1);
        else            push_expected(12, 12, 5, 1, 2);
        beats = 0; m = 0; finished = 0; pulsed = 0;
        @(negedge clk);
        sel = which; start = 1'b1; enable = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (!finished && m < 20000) begin
            start = 1'b0;
            if (beats > 0) enable = ($urandom_range(0, 99) >= 32'(stall_pct));
            else           enable = 1'b1;
            if (pulse_at >= 0 && !pulsed && beats == pulse_at) begin
                start = 1'b1; enable = 1'b1; pulsed = 1;
            end
            #1;
            if (obs_valid) begin
                got = '{addr: obs_addr, chan: obs_chan, first: obs_first, last: obs_last};
                if (beats == 0) begin
                    checks++;
                    if (m !== exp_lat) begin
                        errors++;
                        $display("FAIL first_beat_latency dut=%0d got %0d cycles, want %0d", which, m, exp_lat);
                    end
                end
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL extra_beat dut=%0d beat %0d addr %0d, want no beat", which, beats, obs_addr);
                    finished = 1;
                end else begin
                    e = exp_q.pop_front();
                    if (got !== e) begin
                        errors++;
                        $display("FAIL beat dut=%0d #%0d addr/chan/first/last got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d",
                                 which, beats, got.addr, got.chan, got.first, got.last,
                                 e.addr, e.chan, e.first, e.last);
                    end
                end
                spot = -1;
                if (which == 0 && stall_pct == 0) begin
                    case (beats)
                        5: spot = 12;   24: spot = 52;   25: spot = 1;
                        1599: spot = 143; 1600: spot = 144; 3199: spot = 287;
                        default: spot = -1;
                    endcase
                end else if (which == 1) begin
                    case (beats)
                        2: spot = 6; 4: spot = 2; 12: spot = 12; 35: spot = 35;
                        default: spot = -1;
                    endcase
                end
                if (spot >= 0) begin
                    checks++;
                    if (obs_addr !== 9'(spot)) begin
                        errors++;
                        $display("FAIL spot_addr dut=%0d beat %0d got %0d want %0d", which, beats, obs_addr, spot);
                    end
                end
                if (which == 0 && stall_pct == 0 && (beats == 1599 || beats == 1600)) begin
                    checks++;
                    if (obs_chan !== (beats == 1600)) begin
                        errors++;
                        $display("FAIL chan_boundary beat %0d got %0d want %0d", beats, obs_chan, beats == 1600);
                    end
                end
                beats++;
                if (reset_at >= 0 && beats == reset_at) begin
                    rst = 1'b1;
                    #1;
                    checks++;
                    if ({obs_addr, obs_valid, obs_first, obs_last, obs_chan, obs_done} !== '0) begin
                        errors++;
                        $display("FAIL reset_mid_run addr %0d valid %0d first %0d last %0d chan %0d done %0d, want all 0",
                                 obs_addr, obs_valid, obs_first, obs_last, obs_chan, obs_done);
                    end
                    @(negedge clk);
                    rst = 1'b0;
                    exp_q.delete();
                    finished = 1;
                end
            end else if (beats > 0 && exp_q.size() == 0) begin
                checks++;
                if (obs_done !== 1'b1) begin
                    errors++;
                    $display("FAIL done_after_last dut=%0d got %0d want 1", which, obs_done);
                end
                checks++;
                if (beats !== total) begin
                    errors++;
                    $display("FAIL beat_count dut=%0d got %0d want %0d", which, beats, total);
                end
                finished = 1;
            end
            if (!finished) begin
                @(negedge clk);
                m++;
            end
        end
        if (!finished) begin
            checks++;
            errors++;
            $display("FAIL timeout dut=%0d beats %0d of %0d", which, beats, total);
        end
        enable = 1'b1;
        start  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; enable = 1'b0; sel = 0;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            sel = d;
            #1;
            checks++;
            if ({obs_addr, obs_valid, obs_first, obs_last, obs_chan, obs_done} !== '0) begin
                errors++;
                $display("FAIL reset_state dut=%0d addr %0d valid %0d first %0d last %0d chan %0d done %0d, want all 0",
                         d, obs_addr, obs_valid, obs_first, obs_last, obs_chan, obs_done);
            end
        end
        @(negedge clk);
        rst = 1'b0; enable = 1'b1; sel = 0;
    endtask

    task automatic test_full_run();
        run_scenario(0, 0, -1, -1, 1, 3200);
    endtask

    task automatic test_strided();
        run_scenario(1, 0, -1, -1, 1, 36);
    endtask

    task automatic test_delay_stall();
        run_scenario(2, 30, -1, -1, 4, 3200);
    endtask

    task automatic test_start_ignored();
        run_scenario(0, 0, 100, -1, 1, 3200);
    endtask

    task automatic test_back_to_back();
        run_scenario(0, 0, -1, -1, 1, 3200);
    endtask

    task automatic test_reset_mid_run();
        run_scenario(0, 0, -1, 1500, 1, 3200);
        run_scenario(0, 0, -1, -1, 1, 3200);
    endtask

    initial begin
        checks = 0; errors = 0;
        sel = 0; start = 1'b0; enable = 1'b0; rst = 1'b1;
        test_reset();
        test_full_run();
        test_strided();
        test_delay_stall();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
